// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives loads/stores onto a req/gnt/rvalid port, stalls upstream, registers MEM/WB.
// Optional build macro MEM_ADDR_CHECK_EN faults LD/ST whose word address is >= DMEM_DEPTH without issuing a request.
module mem_stage #(
    parameter int WAIT_LIMIT = 16,
    parameter int DMEM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exmem_valid,
    input  logic [15:0] exmem_alu_out,
    input  logic [15:0] exmem_value_to_write,
    input  logic        exmem_mem_read,
    input  logic        exmem_mem_write,
    input  logic        exmem_reg_write,
    input  logic [3:0]  exmem_dst,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [15:0] dmem_rdata,
    output logic        memwb_valid,
    output logic [15:0] memwb_data,
    output logic [3:0]  memwb_dst,
    output logic        memwb_reg_write,
    output logic        mem_fault,
    output logic [1:0]  fsm_state
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_GNT   = 2'd1;
    localparam logic [1:0] WAIT_RDATA = 2'd2;
    localparam logic [7:0] LAST_CNT   = 8'(WAIT_LIMIT - 1);

    logic [1:0]  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        is_load, is_store, illegal, addr_bad;
    logic        launch, req_phase, last_cycle, granted;
    logic        done, fault, done_rw;
    logic [15:0] done_data;

    assign is_load  = exmem_mem_read & ~exmem_mem_write;
    assign is_store = exmem_mem_write & ~exmem_mem_read;
    assign illegal  = exmem_mem_read & exmem_mem_write;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = (is_load | is_store) && ({16'd0, exmem_alu_out} >= 32'(DMEM_DEPTH));
`else
    logic depth_unused;
    assign depth_unused = ^32'(DMEM_DEPTH);
    assign addr_bad     = 1'b0;
`endif

    // Handshake: dmem_req/we/addr/wdata are valid together; a request is accepted in any cycle
    // where dmem_req and dmem_gnt are both high. Load data is taken only in WAIT_RDATA on dmem_rvalid.
    assign launch     = (state == IDLE) && exmem_valid && (is_load | is_store) && !addr_bad;
    assign req_phase  = launch || (state == WAIT_GNT);
    assign last_cycle = (cnt == LAST_CNT);
    assign granted    = req_phase & dmem_gnt;

    assign dmem_req   = req_phase;
    assign dmem_we    = is_store;
    assign dmem_addr  = exmem_alu_out;
    assign dmem_wdata = exmem_value_to_write;
    assign fsm_state  = state;

    always_comb begin
        done      = 1'b0;
        fault     = 1'b0;
        done_data = exmem_alu_out;
        done_rw   = exmem_reg_write;
        case (state)
            IDLE: begin
                if (exmem_valid) begin
                    if (illegal || addr_bad) begin
                        done  = 1'b1;
                        fault = 1'b1;
                    end else if (!is_load && !is_store) begin
                        done = 1'b1;
                    end else if (granted && is_store) begin
                        done    = 1'b1;
                        done_rw = 1'b0;
                    end
                end
            end
            WAIT_GNT: begin
                if (granted && is_store) begin
                    done    = 1'b1;
                    done_rw = 1'b0;
                end else if (!dmem_gnt && last_cycle) begin
                    done  = 1'b1;
                    fault = 1'b1;
                end
            end
            WAIT_RDATA: begin
                if (dmem_rvalid) begin
                    done      = 1'b1;
                    done_data = dmem_rdata;
                end else if (last_cycle) begin
                    done  = 1'b1;
                    fault = 1'b1;
                end
            end
            default: ;
        endcase
        if (fault) begin
            done_data = 16'd0;
            done_rw   = 1'b0;
        end
    end

    assign mem_stall = exmem_valid & ~done;

    // The counter is 0 in the first cycle of each phase; the launch cycle is grant-phase cycle 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (launch) begin
                    if (granted) begin
                        state_nxt = is_load ? WAIT_RDATA : IDLE;
                    end else begin
                        state_nxt = WAIT_GNT;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            WAIT_GNT: begin
                if (granted) begin
                    state_nxt = is_load ? WAIT_RDATA : IDLE;
                    cnt_nxt   = 8'd0;
                end else if (last_cycle) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            WAIT_RDATA: begin
                if (dmem_rvalid || last_cycle) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Non-done cycles insert a bubble; the data register holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_valid     <= 1'b0;
            memwb_data      <= 16'd0;
            memwb_dst       <= 4'd0;
            memwb_reg_write <= 1'b0;
            mem_fault       <= 1'b0;
        end else begin
            mem_fault <= done & fault;
            if (done) begin
                memwb_valid     <= 1'b1;
                memwb_data      <= done_data;
                memwb_dst       <= exmem_dst;
                memwb_reg_write <= done_rw;
            end else begin
                memwb_valid     <= 1'b0;
                memwb_reg_write <= 1'b0;
            end
        end
    end
endmodule
